// File: rtl/mda_capture.sv
//-----------------------------------------------------------------------------
// mda_capture
//
// Front end for the raw TTL signals of an MDA card. Each raw input is brought
// into the clk domain through a two-flop synchroniser. The block rebuilds the
// dot phase (clk runs at twice the dot rate), the horizontal and vertical
// position, and a display_enable window. A small lock FSM decides whether the
// measured line timing can be trusted. All outputs are registered and leave
// three clk after the corresponding raw input change.
//
// Ports:
//   clk            capture clock, 2x MDA dot rate
//   rst_n          asynchronous active-low reset
//   raw_video      MDA video TTL (asynchronous)
//   raw_intensity  MDA intensity TTL (asynchronous)
//   raw_hsync      MDA hsync TTL, active-high (asynchronous)
//   raw_vsync      MDA vsync TTL, active level VSYNC_POL (asynchronous)
//   video          captured video bit
//   intensity      captured intensity bit
//   hsync          hsync, active-high
//   vsync          vsync, normalised to active-high
//   display_enable high inside the active window while locked
//   locked         line timing locked
//   h_count        dot index since the last hsync rise (saturates at 2047)
//   v_count        line index since the last vsync leading edge (sat. 1023)
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module mda_capture #(
  parameter int H_TOTAL    = 882,
  parameter int H_START    = 4,
  parameter int H_ACTIVE   = 720,
  parameter int V_START    = 0,
  parameter int V_ACTIVE   = 350,
  parameter int LINE_TOL   = 2,
  parameter int LOCK_LINES = 8,
  parameter bit VSYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        raw_video,
  input  logic        raw_intensity,
  input  logic        raw_hsync,
  input  logic        raw_vsync,
  output logic        video,
  output logic        intensity,
  output logic        hsync,
  output logic        vsync,
  output logic        display_enable,
  output logic        locked,
  output logic [10:0] h_count,
  output logic [9:0]  v_count
);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [10:0] H_MAX    = 11'd2047;
  localparam logic [9:0]  V_MAX    = 10'd1023;
  // Window bounds are held in 12 bits so H_START+H_ACTIVE cannot overflow.
  localparam logic [11:0] H_LO     = 12'(H_START);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_LO     = 12'(V_START);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] LINE_MIN = 12'(H_TOTAL - LINE_TOL);
  localparam logic [11:0] LINE_MAX = 12'(H_TOTAL + LINE_TOL);
  localparam logic [3:0]  LOCK_CNT = 4'(LOCK_LINES);

  // Synchroniser stages
  logic vid_s1_q, vid_s1_d, vid_s2_q, vid_s2_d;
  logic int_s1_q, int_s1_d, int_s2_q, int_s2_d;
  logic hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d, hs_s3_q, hs_s3_d;
  logic vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_s3_q, vs_s3_d;

  // Registered outputs
  logic video_q, video_d, intensity_q, intensity_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic de_q, de_d, locked_q, locked_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;

  // Timing recovery state
  logic       phase_q, phase_d;
  logic       seen_hs_q, seen_hs_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  state_t     state_q, state_d;

  // Combinational helpers
  logic        hs_rise;
  logic        vs_lead;
  logic [11:0] measured;
  logic        line_good;
  logic [11:0] h_off;
  logic [11:0] v_off;
  logic        h_in;
  logic        v_in;

  // Next-state logic: synchronisers, counters, lock FSM and output window
  always_comb begin
    // Synchroniser chains; vsync is normalised to active-high on entry so a
    // cleared synchroniser always reads as "not in vsync".
    vid_s1_d = raw_video;
    vid_s2_d = vid_s1_q;
    int_s1_d = raw_intensity;
    int_s2_d = int_s1_q;
    hs_s1_d  = raw_hsync;
    hs_s2_d  = hs_s1_q;
    hs_s3_d  = hs_s2_q;
    vs_s1_d  = raw_vsync ^ ~VSYNC_POL;
    vs_s2_d  = vs_s1_q;
    vs_s3_d  = vs_s2_q;

    hs_rise = hs_s2_q & ~hs_s3_q;
    vs_lead = vs_s2_q & ~vs_s3_q;

    video_d     = vid_s2_q;
    intensity_d = int_s2_q;
    hsync_d     = hs_s2_q;
    vsync_d     = vs_s2_q;

    // Dot phase restarts at every hsync rise so dot 0 begins on that clk.
    if (hs_rise) begin
      phase_d = 1'b0;
    end else begin
      phase_d = ~phase_q;
    end

    if (hs_rise) begin
      h_cnt_d = 11'd0;
    end else if (phase_q && (h_cnt_q != H_MAX)) begin
      h_cnt_d = h_cnt_q + 11'd1;
    end else begin
      h_cnt_d = h_cnt_q;
    end

    // A vsync leading edge overrides an hsync rise in the same clk.
    if (vs_lead) begin
      v_cnt_d = 10'd0;
    end else if (hs_rise && (v_cnt_q != V_MAX)) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end

    // Line length in dots: the count before clearing includes the dot that
    // is completing on this clk when phase is 1, so an N-dot line measures N.
    measured  = {1'b0, h_cnt_q} + {11'd0, phase_q};
    // The first hsync after reset measures from an unknown origin.
    line_good = seen_hs_q && (measured >= LINE_MIN) && (measured <= LINE_MAX);
    seen_hs_d = seen_hs_q | hs_rise;

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      SEARCH: begin
        if (hs_rise) begin
          if (line_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if ((good_cnt_q + 4'd1) >= LOCK_CNT) begin
              state_d = LOCKED;
            end else begin
              state_d = SEARCH;
            end
          end else begin
            good_cnt_d = 4'd0;
          end
        end else begin
          good_cnt_d = good_cnt_q;
        end
      end
      LOCKED: begin
        // A bad line or a runaway h_count (hsync lost) drops lock at once.
        if ((hs_rise && !line_good) || (h_cnt_d == H_MAX)) begin
          state_d    = SEARCH;
          good_cnt_d = 4'd0;
        end else begin
          state_d    = LOCKED;
        end
      end
      default: begin
        state_d    = SEARCH;
        good_cnt_d = 4'd0;
      end
    endcase

    locked_d = (state_d == LOCKED);

    // Window evaluated on next-cycle position so display_enable lines up with
    // the registered video bit. Offsets below the start wrap to large values.
    h_off = {1'b0, h_cnt_d} - H_LO;
    v_off = {2'b00, v_cnt_d} - V_LO;
    h_in  = (h_off < H_ACT);
    v_in  = (v_off < V_ACT);
    de_d  = locked_d && h_in && v_in;
  end

  // State and output registers; cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_s1_q    <= 1'b0;
      vid_s2_q    <= 1'b0;
      int_s1_q    <= 1'b0;
      int_s2_q    <= 1'b0;
      hs_s1_q     <= 1'b0;
      hs_s2_q     <= 1'b0;
      hs_s3_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      vs_s3_q     <= 1'b0;
      video_q     <= 1'b0;
      intensity_q <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      locked_q    <= 1'b0;
      h_cnt_q     <= 11'd0;
      v_cnt_q     <= 10'd0;
      phase_q     <= 1'b0;
      seen_hs_q   <= 1'b0;
      good_cnt_q  <= 4'd0;
      state_q     <= SEARCH;
    end else begin
      vid_s1_q    <= vid_s1_d;
      vid_s2_q    <= vid_s2_d;
      int_s1_q    <= int_s1_d;
      int_s2_q    <= int_s2_d;
      hs_s1_q     <= hs_s1_d;
      hs_s2_q     <= hs_s2_d;
      hs_s3_q     <= hs_s3_d;
      vs_s1_q     <= vs_s1_d;
      vs_s2_q     <= vs_s2_d;
      vs_s3_q     <= vs_s3_d;
      video_q     <= video_d;
      intensity_q <= intensity_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      locked_q    <= locked_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      phase_q     <= phase_d;
      seen_hs_q   <= seen_hs_d;
      good_cnt_q  <= good_cnt_d;
      state_q     <= state_d;
    end
  end

  assign video          = video_q;
  assign intensity      = intensity_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign display_enable = de_q;
  assign locked         = locked_q;
  assign h_count        = h_cnt_q;
  assign v_count        = v_cnt_q;

endmodule
